input_port_buffer_stage: RTL and testbench



---
 rtl/input_port_buffer_stage_pkg.sv | 33 +++
 rtl/input_port_buffer_stage_if.sv | 26 ++
 rtl/input_port_buffer_stage_vc_buffer.sv | 127 ++++++++++++
 rtl/input_port_buffer_stage.sv | 61 ++++++
 tb/tb_input_port_buffer_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/input_port_buffer_stage_pkg.sv
// Shared flit layout, type encodings and per-VC state encodings for the input port buffer stage.
// Flit layout: [15:14] type, [13:12] VC id, [11:0] payload.
package input_port_buffer_stage_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned V       = 4;
  localparam int unsigned TypeLsb = 14;
  localparam int unsigned TypeW   = 2;
  localparam int unsigned VcIdLsb = 12;
  localparam int unsigned VcIdW   = $clog2(V);

  typedef enum logic [1:0] {
    FlitBody     = 2'b00,
    FlitHead     = 2'b01,
    FlitTail     = 2'b10,
    FlitHeadTail = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VcIdle   = 2'b00,
    VcWaitVa = 2'b01,
    VcActive = 2'b10
  } vc_state_e;

  function automatic logic is_head(flit_type_e t);
    return (t == FlitHead) || (t == FlitHeadTail);
  endfunction

  function automatic logic is_tail(flit_type_e t);
    return (t == FlitTail) || (t == FlitHeadTail);
  endfunction

endpackage

// File: rtl/input_port_buffer_stage_if.sv
// Link/allocator-facing signal bundle of the input port buffer stage.
interface input_port_buffer_stage_if;
  import input_port_buffer_stage_pkg::*;

  logic            valid;
  logic [DW-1:0]   data;
  logic [V-1:0]    rd_en;
  logic [V-1:0]    va_grant;
  logic [V*DW-1:0] head_data;
  logic [V-1:0]    vc_not_empty;
  logic [V-1:0]    va_req;
  logic [V-1:0]    vc_active;
  logic [V-1:0]    credit_upd;
  logic            overflow_err;

  modport master (
    output valid, data, rd_en, va_grant,
    input  head_data, vc_not_empty, va_req, vc_active, credit_upd, overflow_err
  );

  modport slave (
    input  valid, data, rd_en, va_grant,
    output head_data, vc_not_empty, va_req, vc_active, credit_upd, overflow_err
  );

endinterface

// File: rtl/input_port_buffer_stage_vc_buffer.sv
// One virtual channel: fall-through FIFO, packet state machine and credit return register.
module input_vc_buffer
  import input_port_buffer_stage_pkg::*;
#(
  parameter int unsigned VCID      = 0,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic          va_grant_i,
  output logic [DW-1:0] head_data_o,
  output logic          not_empty_o,
  output logic          va_req_o,
  output logic          active_o,
  output logic          credit_upd_o,
  output logic          overflow_o
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(BUF_DEPTH);

  logic [DW-1:0]    mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             credit_q;
  logic             va_req_q, active_q;
  vc_state_e        state_q;

  logic             empty, full, push, pop;
  logic [DW-1:0]    head;
  flit_type_e       head_type;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  assign pop   = rd_en_i & ~empty;
  // A full FIFO still accepts a write when a slot frees on the same edge.
  assign push  = wr_en_i & (~full | pop);

  assign head      = mem_q[rd_ptr_q];
  assign head_type = flit_type_e'(head[TypeLsb +: TypeW]);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q | (wr_en_i & full & ~pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      credit_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      credit_q   <= pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // A body/tail flit at the head of an idle VC is a protocol error and is left stuck there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= VcIdle;
      va_req_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      unique case (state_q)
        VcIdle: begin
          if (!empty && is_head(head_type)) begin
            state_q  <= VcWaitVa;
            va_req_q <= 1'b1;
          end
        end
        VcWaitVa: begin
          if (va_grant_i) begin
            state_q  <= VcActive;
            va_req_q <= 1'b0;
            active_q <= 1'b1;
          end
        end
        VcActive: begin
          if (pop && is_tail(head_type)) begin
            state_q  <= VcIdle;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= VcIdle;
          va_req_q <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign head_data_o  = empty ? '0 : head;
  assign not_empty_o  = ~empty;
  assign va_req_o     = va_req_q;
  assign active_o     = active_q;
  assign credit_upd_o = credit_q;
  assign overflow_o   = overflow_q;

  wr_vcid_match_a: assert property (@(posedge clk) disable iff (!rstn)
    wr_en_i |-> (wr_data_i[VcIdLsb +: VcIdW] == VcIdW'(VCID)));

endmodule

// File: rtl/input_port_buffer_stage.sv
// Router input port: steers arriving flits to per-VC buffers and merges their overflow flags.
module input_port_buffer_stage
  import input_port_buffer_stage_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned PTR_W     = $clog2(BUF_DEPTH)
) (
  input logic                      clk,
  input logic                      rstn,
  input_port_buffer_stage_if.slave bus
);

  logic [VcIdW-1:0] wr_vcid;
  logic [V-1:0]     wr_en;
  logic [V-1:0]     overflow;
  logic [V*DW-1:0]  head_data;
  logic [V-1:0]     not_empty;
  logic [V-1:0]     va_req;
  logic [V-1:0]     active;
  logic [V-1:0]     credit_upd;

  assign wr_vcid = bus.data[VcIdLsb +: VcIdW];

  always_comb begin
    wr_en = '0;
    if (bus.valid) begin
      wr_en[wr_vcid] = 1'b1;
    end
  end

  for (genvar v = 0; v < V; v++) begin : g_vc
    input_vc_buffer #(
      .VCID      (v),
      .BUF_DEPTH (BUF_DEPTH),
      .PTR_W     (PTR_W)
    ) u_vc (
      .clk          (clk),
      .rstn         (rstn),
      .wr_en_i      (wr_en[v]),
      .wr_data_i    (bus.data),
      .rd_en_i      (bus.rd_en[v]),
      .va_grant_i   (bus.va_grant[v]),
      .head_data_o  (head_data[v*DW +: DW]),
      .not_empty_o  (not_empty[v]),
      .va_req_o     (va_req[v]),
      .active_o     (active[v]),
      .credit_upd_o (credit_upd[v]),
      .overflow_o   (overflow[v])
    );
  end

  assign bus.head_data    = head_data;
  assign bus.vc_not_empty = not_empty;
  assign bus.va_req       = va_req;
  assign bus.vc_active    = active;
  assign bus.credit_upd   = credit_upd;
  assign bus.overflow_err = |overflow;

  rd_en_onehot_a: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.rd_en));

endmodule

// File: tb/tb_input_port_buffer_stage.sv
// Directed bench for input_port_buffer_stage with hand-computed expectations.
module tb_input_port_buffer_stage;
  import input_port_buffer_stage_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   vectors;
  int   miscompares;

  always #5 clk = ~clk;

  input_port_buffer_stage_if bus ();

  input_port_buffer_stage #(
    .BUF_DEPTH (4)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] hd(input int v);
    return bus.head_data[v*DW +: DW];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_not_empty"}, 64'(bus.vc_not_empty), 64'h0);
    chk({tag, "_va_req"}, 64'(bus.va_req), 64'h0);
    chk({tag, "_active"}, 64'(bus.vc_active), 64'h0);
    chk({tag, "_credit"}, 64'(bus.credit_upd), 64'h0);
    chk({tag, "_overflow"}, 64'(bus.overflow_err), 64'h0);
    chk({tag, "_head_data"}, bus.head_data, 64'h0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rstn         = 1'b0;
    bus.valid    = 1'b0;
    bus.data     = '0;
    bus.rd_en    = '0;
    bus.va_grant = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Single head+tail flit on VC2
    bus.valid = 1'b1;
    bus.data  = 16'hE0A1;
    tick();
    bus.valid = 1'b0;
    chk("t1_not_empty", 64'(bus.vc_not_empty), 64'h4);
    chk("t1_head", 64'(hd(2)), 64'hE0A1);
    chk("t1_va_req_lo", 64'(bus.va_req), 64'h0);
    tick();
    chk("t1_va_req", 64'(bus.va_req), 64'h4);
    bus.va_grant = 4'b0100;
    tick();
    bus.va_grant = '0;
    chk("t1_active", 64'(bus.vc_active), 64'h4);
    chk("t1_va_req_drop", 64'(bus.va_req), 64'h0);
    bus.rd_en = 4'b0100;
    tick();
    bus.rd_en = '0;
    chk("t1_credit", 64'(bus.credit_upd), 64'h4);
    chk("t1_idle", 64'(bus.vc_active), 64'h0);
    chk("t1_empty", 64'(bus.vc_not_empty), 64'h0);
    tick();
    chk("t1_credit_once", 64'(bus.credit_upd), 64'h0);
    chk("t1_no_req", 64'(bus.va_req), 64'h0);

    // VC1 full of body flits, then simultaneous write and read
    for (int i = 0; i < 4; i++) begin
      bus.valid = 1'b1;
      bus.data  = 16'h1011 + 16'(i);
      tick();
    end
    bus.data  = 16'h1015;
    bus.rd_en = 4'b0010;
    tick();
    bus.valid = 1'b0;
    bus.rd_en = '0;
    chk("t3_credit", 64'(bus.credit_upd), 64'h2);
    chk("t3_no_overflow", 64'(bus.overflow_err), 64'h0);
    chk("t3_head", 64'(hd(1)), 64'h1012);
    chk("t3_body_no_req", 64'(bus.va_req), 64'h0);
    tick();
    chk("t3_credit_once", 64'(bus.credit_upd), 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_head", 64'(hd(1)), 64'h1012 + 64'(i));
      bus.rd_en = 4'b0010;
      tick();
      chk("t3_drain_credit", 64'(bus.credit_upd), 64'h2);
    end
    bus.rd_en = '0;
    chk("t3_drained", 64'(bus.vc_not_empty), 64'h0);

    // Read strobe on empty VC3
    bus.rd_en = 4'b1000;
    tick();
    bus.rd_en = '0;
    chk("t4_no_credit", 64'(bus.credit_upd), 64'h0);
    chk("t4_empty", 64'(bus.vc_not_empty), 64'h0);
    chk("t4_no_req", 64'(bus.va_req), 64'h0);
    chk("t4_no_active", 64'(bus.vc_active), 64'h0);

    // VC0 packet fills FIFO; fifth write overflows
    bus.valid = 1'b1;
    bus.data  = 16'h4001;
    tick();
    bus.data  = 16'h0002;
    tick();
    bus.data  = 16'h0003;
    tick();
    bus.data  = 16'h8004;
    tick();
    bus.data  = 16'h0005;
    tick();
    bus.valid = 1'b0;
    chk("t2_overflow", 64'(bus.overflow_err), 64'h1);
    chk("t2_head_kept", 64'(hd(0)), 64'h4001);
    chk("t2_va_req", 64'(bus.va_req), 64'h1);
    chk("t2_not_empty", 64'(bus.vc_not_empty), 64'h1);
    bus.va_grant = 4'b0001;
    tick();
    bus.va_grant = '0;
    chk("t2_active", 64'(bus.vc_active), 64'h1);
    chk("t2_req_drop", 64'(bus.va_req), 64'h0);

    // Drain at one flit per cycle while the next head arrives
    bus.rd_en = 4'b0001;
    bus.valid = 1'b1;
    bus.data  = 16'h4009;
    tick();
    bus.valid = 1'b0;
    chk("t5_credit0", 64'(bus.credit_upd), 64'h1);
    chk("t5_head0", 64'(hd(0)), 64'h0002);
    chk("t5_overflow_sticky", 64'(bus.overflow_err), 64'h1);
    tick();
    chk("t5_credit1", 64'(bus.credit_upd), 64'h1);
    chk("t5_head1", 64'(hd(0)), 64'h0003);
    tick();
    chk("t5_credit2", 64'(bus.credit_upd), 64'h1);
    chk("t5_head2", 64'(hd(0)), 64'h8004);
    chk("t5_still_active", 64'(bus.vc_active), 64'h1);
    tick();
    bus.rd_en = '0;
    chk("t5_credit3", 64'(bus.credit_upd), 64'h1);
    chk("t5_idle", 64'(bus.vc_active), 64'h0);
    chk("t5_req_gap", 64'(bus.va_req), 64'h0);
    chk("t5_next_head", 64'(hd(0)), 64'h4009);
    tick();
    chk("t5_credit_end", 64'(bus.credit_upd), 64'h0);
    chk("t5_req_again", 64'(bus.va_req), 64'h1);

    // VC1 two flits active, then asynchronous reset mid-cycle
    bus.valid = 1'b1;
    bus.data  = 16'h5021;
    tick();
    bus.data  = 16'h1022;
    tick();
    bus.valid = 1'b0;
    chk("t6_va_req", 64'(bus.va_req), 64'h3);
    bus.va_grant = 4'b0010;
    tick();
    bus.va_grant = '0;
    chk("t6_active", 64'(bus.vc_active), 64'h2);
    chk("t6_not_empty", 64'(bus.vc_not_empty), 64'h3);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("t6_async");
    tick();
    rstn = 1'b1;
    tick();
    chk("t6_no_credit0", 64'(bus.credit_upd), 64'h0);
    chk("t6_flits_lost", 64'(bus.vc_not_empty), 64'h0);
    tick();
    chk("t6_no_credit1", 64'(bus.credit_upd), 64'h0);
    chk("t6_no_req", 64'(bus.va_req), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
